// File: rtl/nuc_pkg.sv
// Shared definitions for the NUC pixel corrector slice.
package nuc_pkg;

  // Bad-pixel replacement policy selected by bad_mode.
  typedef enum logic [1:0] {
    BAD_ZERO   = 2'b00,
    BAD_HOLD   = 2'b01,
    BAD_FILL   = 2'b10,
    BAD_IGNORE = 2'b11
  } bad_mode_e;

  // Enabled cycles from input sample to output register.
  localparam int unsigned NUC_LATENCY = 4;

  // Signed sum width wide enough that product + shifted offset + round never wraps.
  function automatic int unsigned nuc_sum_width(input int unsigned din_w,
                                                input int unsigned gain_w,
                                                input int unsigned ofst_w,
                                                input int unsigned gain_frac);
    int unsigned a;
    int unsigned b;
    a = din_w + gain_w;
    b = ofst_w + gain_frac;
    return ((a > b) ? a : b) + 2;
  endfunction

endpackage

// File: rtl/nuc_clip_counter.sv
// Per-frame clipped-pixel counter; reports the previous frame's count on each sof.
module nuc_clip_counter import nuc_pkg::*; #(
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 cen,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic                 pix_clip,
  output logic [CNT_WIDTH-1:0] clip_cnt,
  output logic                 clip_cnt_valid
);

  logic [CNT_WIDTH-1:0] acc;

  // Accumulate clips, latch and restart on sof; a clipped sof pixel belongs to the new frame.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc            <= '0;
      clip_cnt       <= '0;
      clip_cnt_valid <= 1'b0;
    end else begin
      // Pulse is cleared on stalled cycles so it never stretches.
      clip_cnt_valid <= cen & pix_valid & pix_sof;
      if (cen && pix_valid) begin
        if (pix_sof) begin
          clip_cnt <= acc;
          acc      <= pix_clip ? CNT_WIDTH'(1) : '0;
        end else if (pix_clip && (acc != '1)) begin
          acc <= acc + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nuc_dsp_gen.sv
// NUC pixel corrector: dout = sat((din*gain + ofst<<GAIN_FRAC [+ half LSB]) >> GAIN_FRAC),
// four-stage pipeline with sideband, bad-pixel replacement and clip statistics.
module nuc_dsp_gen import nuc_pkg::*; #(
  parameter int unsigned DIN_WIDTH  = 14,
  parameter int unsigned GAIN_WIDTH = 15,
  parameter int unsigned GAIN_FRAC  = 14,
  parameter int unsigned OFST_WIDTH = 16,
  parameter int unsigned ROUND      = 1,
  parameter int unsigned CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  cen,
  input  logic                  bypass,
  input  logic [1:0]            bad_mode,
  input  logic [DIN_WIDTH-1:0]  bad_fill,
  input  logic                  din_valid,
  input  logic                  din_sol,
  input  logic                  din_sof,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic [GAIN_WIDTH:0]   gain,
  input  logic [OFST_WIDTH-1:0] ofst,
  output logic                  dout_valid,
  output logic                  dout_sol,
  output logic                  dout_sof,
  output logic [DIN_WIDTH-1:0]  dout,
  output logic                  dout_good,
  output logic                  dout_repl,
  output logic                  dout_clip,
  output logic [CNT_WIDTH-1:0]  clip_cnt,
  output logic                  clip_cnt_valid
);

  localparam int unsigned PW = DIN_WIDTH + GAIN_WIDTH;
  localparam int unsigned SW = nuc_sum_width(DIN_WIDTH, GAIN_WIDTH, OFST_WIDTH, GAIN_FRAC);
  localparam logic signed [SW-1:0] RND =
    ((ROUND != 0) && (GAIN_FRAC > 0)) ? (SW'(1) <<< (GAIN_FRAC - 1)) : '0;

  logic                         s1_valid, s1_sol, s1_sof, s1_good;
  logic [DIN_WIDTH-1:0]         s1_din;
  logic [GAIN_WIDTH-1:0]        s1_coef;
  logic signed [OFST_WIDTH-1:0] s1_ofst;

  logic                         s2_valid, s2_sol, s2_sof, s2_good;
  logic [DIN_WIDTH-1:0]         s2_din;
  logic [PW-1:0]                s2_prod;
  logic signed [OFST_WIDTH-1:0] s2_ofst;

  logic                         s3_valid, s3_sol, s3_sof, s3_good;
  logic [DIN_WIDTH-1:0]         s3_din;
  logic signed [SW-1:0]         s3_sum;

  logic signed [SW-1:0]         prod_ext, ofst_sh, sum_next, r;
  logic [DIN_WIDTH-1:0]         corr, eff_last, last_good, nxt_dout;
  logic                         corr_clip, nxt_good, nxt_repl, nxt_clip;
  bad_mode_e                    mode;

  // S3 adder operands: zero-extended product, sign-extended scaled offset, round constant.
  always_comb begin
    prod_ext = $signed(SW'(s2_prod));
    ofst_sh  = SW'(s2_ofst) <<< GAIN_FRAC;
    sum_next = prod_ext + ofst_sh + RND;
  end

  // S1..S3: register inputs, multiply, add; sideband travels alongside.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0; s1_sol <= 1'b0; s1_sof <= 1'b0; s1_good <= 1'b0;
      s1_din   <= '0;   s1_coef <= '0;  s1_ofst <= '0;
      s2_valid <= 1'b0; s2_sol <= 1'b0; s2_sof <= 1'b0; s2_good <= 1'b0;
      s2_din   <= '0;   s2_prod <= '0;  s2_ofst <= '0;
      s3_valid <= 1'b0; s3_sol <= 1'b0; s3_sof <= 1'b0; s3_good <= 1'b0;
      s3_din   <= '0;   s3_sum  <= '0;
    end else if (cen) begin
      s1_valid <= din_valid;
      s1_sol   <= din_sol & din_valid;
      s1_sof   <= din_sof & din_valid;
      s1_good  <= gain[GAIN_WIDTH];
      s1_din   <= din;
      s1_coef  <= gain[GAIN_WIDTH-1:0];
      s1_ofst  <= $signed(ofst);

      s2_valid <= s1_valid; s2_sol <= s1_sol; s2_sof <= s1_sof; s2_good <= s1_good;
      s2_din   <= s1_din;
      s2_prod  <= PW'(s1_din) * PW'(s1_coef);
      s2_ofst  <= s1_ofst;

      s3_valid <= s2_valid; s3_sol <= s2_sol; s3_sof <= s2_sof; s3_good <= s2_good;
      s3_din   <= s2_din;
      s3_sum   <= sum_next;
    end
  end

  // S4: shift, saturate, then choose between corrected, replacement and bypass values.
  always_comb begin
    mode      = bad_mode_e'(bad_mode);
    r         = s3_sum >>> GAIN_FRAC;
    corr      = '0;
    corr_clip = 1'b0;
    if (r < 0) begin
      corr_clip = 1'b1;
    end else if (r[SW-1:DIN_WIDTH] != '0) begin
      corr      = '1;
      corr_clip = 1'b1;
    end else begin
      corr = r[DIN_WIDTH-1:0];
    end

    // A line start never inherits a pixel from the previous line.
    eff_last = s3_sol ? bad_fill : last_good;

    nxt_dout = corr;
    nxt_good = s3_good;
    nxt_repl = 1'b0;
    nxt_clip = corr_clip;
    if (bypass) begin
      nxt_dout = s3_din;
      nxt_good = 1'b0;
      nxt_clip = 1'b0;
    end else if (!s3_good && (mode != BAD_IGNORE)) begin
      nxt_repl = 1'b1;
      nxt_clip = 1'b0;
      case (mode)
        BAD_ZERO: nxt_dout = '0;
        BAD_HOLD: nxt_dout = eff_last;
        default:  nxt_dout = bad_fill;
      endcase
    end
  end

  // S4 output register and last-good tracker.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dout_valid <= 1'b0; dout_sol <= 1'b0; dout_sof <= 1'b0;
      dout       <= '0;   dout_good <= 1'b0; dout_repl <= 1'b0; dout_clip <= 1'b0;
      last_good  <= '0;
    end else if (cen) begin
      dout_valid <= s3_valid;
      dout_sol   <= s3_sol;
      dout_sof   <= s3_sof;
      dout       <= nxt_dout;
      dout_good  <= nxt_good;
      dout_repl  <= nxt_repl;
      dout_clip  <= nxt_clip;
      if (s3_valid && s3_good && !bypass) begin
        last_good <= corr;
      end
    end
  end

  nuc_clip_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_clip_counter (
    .clk            (clk),
    .aresetn        (aresetn),
    .cen            (cen),
    .pix_valid      (s3_valid),
    .pix_sof        (s3_sof),
    .pix_clip       (nxt_clip),
    .clip_cnt       (clip_cnt),
    .clip_cnt_valid (clip_cnt_valid)
  );

endmodule
